uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit-side buffer between the processor's write port and the UART transmit engine.
- Accepts bytes written by the processor (decoded write strobe plus OUT_PORT[7:0]) into a circular FIFO.
- A handshake FSM drains the FIFO one byte at a time, issuing a single-cycle load pulse to the UART whenever the engine reports ready.
- Lets firmware burst several characters without polling TXRDY per byte.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2, at least 4.
- ADDR_W, 4, log2(DEPTH); pointer width.
- DATA_W, 8, byte width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset: 0 resets all state immediately.
- wr  input  1  write strobe, one cycle per byte (decoded write[n] from the port decoder).
- din  input  DATA_W  byte to enqueue, sampled when wr=1.
- tx_rdy  input  1  level from the UART transmit engine; 1 = idle and able to accept a byte.
- load  output  1  single-cycle pulse to the UART to start transmission of tx_data.
- tx_data  output  DATA_W  byte presented to the UART, registered and held between loads.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag; set when a write is attempted while full.
- clr_ovf  input  1  synchronous clear of overflow.
- half_intr  output  1  see Optional Feature.

Behaviour:
- Reset values (rst=0): pointers 0, count 0, empty 1, full 0, load 0, tx_data 0, overflow 0, half_intr 0, FSM in IDLE. Reset mid-transfer discards all queued bytes; load drops asynchronously.
- Storage: DEPTH x DATA_W register array. wr_ptr and rd_ptr are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- Push: wr=1 and full=0 writes din at wr_ptr and increments wr_ptr.
- Push while full: the byte is dropped and overflow is set, even if a pop occurs in the same cycle. The full decision uses the pre-edge count.
- Pop: occurs only on the IDLE->LOAD transition. tx_data is loaded with mem[rd_ptr], and rd_ptr increments.
- Simultaneous push and pop: count unchanged, both pointers advance.
- count, full and empty are registered; they update at the edge following the event.
- overflow: set has priority over clr_ovf in the same cycle.
- FSM states:
  - IDLE: load=0. If empty=0 and tx_rdy=1, pop and go to LOAD; else stay.
  - LOAD: load=1 for exactly one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: load=0. Stay until tx_rdy=0, then go to WAIT_RDY. This ensures a stale ready level is not mistaken for completion.
  - WAIT_RDY: stay until tx_rdy=1, then go to IDLE.
- Latency: a write in cycle N into an empty FIFO with tx_rdy=1 gives count=1 in cycle N+1, and load=1 with valid tx_data in cycle N+2. count returns to 0 in N+2.
- Back-to-back bytes: the next load occurs no earlier than 2 cycles after tx_rdy returns to 1.
- load is never asserted on consecutive cycles.
- tx_data never changes except on a pop.

Optional Feature:
- Macro: UART_TX_FIFO_HALF_INTR_EN.
- Defined: half_intr is a registered one-cycle pulse when count transitions from DEPTH/2+1 to DEPTH/2 (draining past half). It feeds the RS-flop interrupt latch so firmware can refill. No pulse occurs on upward crossings or when count stays at DEPTH/2.
- Not defined: half_intr is tied to 0; no counter-crossing logic is synthesized.

Test Plan:
- Reset, then one write of 0x41 with tx_rdy=1 → load pulse in cycle N+2, tx_data=0x41; count goes 0→1→0; empty=1 after.
- Write 16 bytes 0x00..0x0F with tx_rdy=0 → full=1, count=16; 17th write of 0xFF → overflow=1 and contents unchanged. Release tx_rdy with engine model → loads emit 0x00..0x0F in order, no 0xFF.
- Engine model holds tx_rdy low 100 cycles per byte → exactly one load per byte; FSM waits in WAIT_RDY; no duplicate loads.
- Push and pop in the same cycle at count=5 → count stays 5; pointer wrap across index 15→0 preserves order.
- Assert rst=0 mid-queue (count=7, in WAIT_RDY) → load=0, count=0, empty=1 immediately; after release the first new write transmits normally.
- With UART_TX_FIFO_HALF_INTR_EN, fill to 10 and drain → a single half_intr pulse on count 9→8. Without the macro, half_intr stays 0.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
//
// Purpose: groups the processor write port, the UART engine handshake and the
// status flags of the transmit FIFO into one bundle.
//
// Signals:
//   wr, din      processor write strobe and byte to enqueue
//   clr_ovf      synchronous clear of the sticky overflow flag
//   tx_rdy       ready level from the UART transmit engine
//   load         single-cycle load pulse to the UART
//   tx_data      byte presented to the UART, held between loads
//   full, empty  occupancy flags
//   count        occupancy, 0..DEPTH
//   overflow     sticky flag, a write was attempted while full
//   half_intr    drain-past-half pulse (tied low unless the feature is built)
//
// Modports:
//   master  the surroundings: processor port decoder plus UART engine
//   slave   the FIFO itself
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              wr;
  logic [DATA_W-1:0] din;
  logic              clr_ovf;
  logic              tx_rdy;
  logic              load;
  logic [DATA_W-1:0] tx_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              half_intr;

  modport master (
    output wr, din, clr_ovf, tx_rdy,
    input  load, tx_data, full, empty, count, overflow, half_intr
  );

  modport slave (
    input  wr, din, clr_ovf, tx_rdy,
    output load, tx_data, full, empty, count, overflow, half_intr
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Purpose: transmit-side buffer between the processor write port and the UART
// transmit engine. Bytes written by the processor are queued in a circular
// FIFO; a handshake FSM drains them one at a time, issuing a single-cycle
// load pulse whenever the engine reports ready.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset (0 clears all state immediately)
//   bus   uart_tx_fifo_if.slave: wr/din/clr_ovf/tx_rdy in,
//         load/tx_data/full/empty/count/overflow/half_intr out
//
// Build option:
//   UART_TX_FIFO_HALF_INTR_EN  when defined, half_intr is a registered
//   one-cycle pulse as count drains from DEPTH/2+1 to DEPTH/2; otherwise
//   half_intr is tied to 0.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_RDY
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              push, pop;
  logic              load_c;

  // Datapath next-state. A write while full is dropped based on the
  // registered (pre-edge) full flag, even if a pop frees a slot this cycle.
  always_comb begin
    push       = bus.wr && !full_q;
    pop        = (state_q == IDLE) && !empty_q && bus.tx_rdy;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      tx_data_d = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);

    // Setting wins over clearing when both happen in the same cycle.
    if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (bus.wr && full_q) begin
      overflow_d = 1'b1;
    end
  end

  // Handshake FSM. WAIT_BUSY insists on seeing tx_rdy fall before WAIT_RDY
  // accepts it rising again, so a stale ready level is never taken as
  // completion of the byte just loaded.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_c  = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.tx_rdy) begin
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.tx_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  // load decodes straight from the state register so reset drops it
  // asynchronously.
  assign bus.load     = load_c;
  assign bus.tx_data  = tx_data_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = overflow_q;

`ifdef UART_TX_FIFO_HALF_INTR_EN
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DEPTH / 2);

  logic half_q, half_d;

  // Fires only on the downward step DEPTH/2+1 -> DEPTH/2.
  always_comb begin
    half_d = (count_q == (CNT_HALF + CNT_ONE)) && (count_d == CNT_HALF);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_q <= 1'b0;
    end else begin
      half_q <= half_d;
    end
  end

  assign bus.half_intr = half_q;
`else
  assign bus.half_intr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Purpose: self-checking bench for uart_tx_fifo. A table of single-cycle
// vectors covers the basic handshake, followed by hand-written sequences for
// fill/overflow, slow-engine draining, pointer wrap with simultaneous
// push/pop, the half-drain pulse and mid-transfer reset.
// Honours UART_TX_FIFO_HALF_INTR_EN to pick the expected half_intr behaviour.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  uart_tx_fifo #(
    .DEPTH  (16),
    .ADDR_W (4),
    .DATA_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Observes half_intr on the falling edge, away from the active edge.
  int half_pulses   = 0;
  int half_count_at = -1;

  always @(negedge clk) begin
    if (bus.half_intr === 1'b1) begin
      half_pulses   = half_pulses + 1;
      half_count_at = int'(bus.count);
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       tx_rdy;
    logic       clr_ovf;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       load;
    logic [7:0] tx_data;
    logic       ovf;
  } vec_t;

  vec_t vecs [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] din,
                               input logic tx_rdy, input logic clr_ovf);
    bus.wr      = wr;
    bus.din     = din;
    bus.tx_rdy  = tx_rdy;
    bus.clr_ovf = clr_ovf;
    step();
  endtask

  // Writes n consecutive byte values with the engine reporting busy.
  task automatic writeBytes(input logic [7:0] first, input int n);
    logic [7:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, v, 1'b0, 1'b0);
      v++;
    end
    bus.wr = 1'b0;
  endtask

  // UART engine model: after each load it holds tx_rdy low for 'busy'
  // cycles (busy >= 2), then raises it. Checks byte order, load spacing and
  // that no extra loads appear once the expected bytes are out.
  task automatic runEngine(input int nbytes, input int busy,
                           input logic [7:0] first);
    int         got       = 0;
    int         extra     = 0;
    int         cycles    = 0;
    int         rise      = -1;
    int         busy_left = 0;
    logic       prev_load = 1'b0;
    logic [7:0] expv;
    bit         done      = 1'b0;
    expv        = first;
    bus.wr      = 1'b0;
    bus.clr_ovf = 1'b0;
    bus.tx_rdy  = 1'b1;
    while (!done && cycles < 4000) begin
      step();
      cycles++;
      if (bus.load === 1'b1) begin
        if (got < nbytes) begin
          checkOutput("tx_data_order", bus.tx_data, expv);
          checkOutput("load_not_back_to_back", prev_load, 0);
          if (rise >= 0) begin
            checkOutput("load_after_rdy_gap", cycles - rise, 2);
          end
          expv++;
          got++;
        end else begin
          extra++;
        end
        busy_left  = busy;
        bus.tx_rdy = 1'b0;
        rise       = -1;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          bus.tx_rdy = 1'b1;
          rise       = cycles;
        end
      end
      prev_load = bus.load;
      if (got == nbytes && rise >= 0 && (cycles - rise) >= 6) begin
        done = 1'b1;
      end
    end
    checkOutput("loads_seen", got, nbytes);
    checkOutput("extra_loads", extra, 0);
    checkOutput("drain_count", bus.count, 0);
    checkOutput("drain_empty", bus.empty, 1);
  endtask

  int half_base;

  initial begin
    // wr din tx_rdy clr | count empty full load tx_data ovf
    vecs[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h41, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h41, 1'b0};
    vecs[4]  = '{1'b1, 8'h42, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
    vecs[5]  = '{1'b1, 8'h43, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h42, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h42, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h42, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h42, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h43, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h43, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h43, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h43, 1'b0};

    rst         = 1'b0;
    bus.wr      = 1'b0;
    bus.din     = 8'h00;
    bus.tx_rdy  = 1'b1;
    bus.clr_ovf = 1'b0;

    // Reset state, sampled while reset is still held.
    #22;
    checkOutput("rst_count", bus.count, 0);
    checkOutput("rst_empty", bus.empty, 1);
    checkOutput("rst_full", bus.full, 0);
    checkOutput("rst_load", bus.load, 0);
    checkOutput("rst_tx_data", bus.tx_data, 8'h00);
    checkOutput("rst_overflow", bus.overflow, 0);
    checkOutput("rst_half_intr", bus.half_intr, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic handshake: latency, stale-ready guard, hold of tx_data.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].tx_rdy, vecs[i].clr_ovf);
      checkOutput($sformatf("vec%0d_count", i), bus.count, vecs[i].count);
      checkOutput($sformatf("vec%0d_empty", i), bus.empty, vecs[i].empty);
      checkOutput($sformatf("vec%0d_full", i), bus.full, vecs[i].full);
      checkOutput($sformatf("vec%0d_load", i), bus.load, vecs[i].load);
      checkOutput($sformatf("vec%0d_tx_data", i), bus.tx_data, vecs[i].tx_data);
      checkOutput($sformatf("vec%0d_ovf", i), bus.overflow, vecs[i].ovf);
    end

    // Fill to 16, then overflow handling.
    writeBytes(8'h00, 16);
    checkOutput("fill_count", bus.count, 16);
    checkOutput("fill_full", bus.full, 1);
    checkOutput("fill_empty", bus.empty, 0);
    checkOutput("fill_load", bus.load, 0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("ovf_set", bus.overflow, 1);
    checkOutput("ovf_count", bus.count, 16);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
    checkOutput("ovf_set_beats_clr", bus.overflow, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_clr", bus.overflow, 0);
    // Write while full with a pop in the same cycle: still dropped.
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
    checkOutput("ovf_pop_count", bus.count, 15);
    checkOutput("ovf_pop_load", bus.load, 1);
    checkOutput("ovf_pop_tx_data", bus.tx_data, 8'h00);
    checkOutput("ovf_pop_overflow", bus.overflow, 1);
    checkOutput("ovf_pop_full", bus.full, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_clr2", bus.overflow, 0);
    runEngine(15, 3, 8'h01);

    // Slow engine: 100 busy cycles per byte.
    writeBytes(8'hA0, 3);
    runEngine(3, 100, 8'hA0);

    // Move pointers to 13, then queue 5 bytes straddling the 15->0 wrap.
    writeBytes(8'h30, 7);
    runEngine(7, 2, 8'h30);
    writeBytes(8'h50, 5);
    checkOutput("wrap_count", bus.count, 5);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("pushpop_count", bus.count, 5);
    checkOutput("pushpop_load", bus.load, 1);
    checkOutput("pushpop_tx_data", bus.tx_data, 8'h50);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    runEngine(5, 2, 8'h51);

    // Half-drain pulse: fill to 10 (upward crossing), then drain.
    half_base = half_pulses;
    writeBytes(8'hC0, 10);
    checkOutput("half_fill_count", bus.count, 10);
    checkOutput("half_no_up_pulse", half_pulses - half_base, 0);
    runEngine(10, 2, 8'hC0);
`ifdef UART_TX_FIFO_HALF_INTR_EN
    checkOutput("half_pulse_count", half_pulses - half_base, 1);
    checkOutput("half_pulse_at", half_count_at, 8);
`else
    checkOutput("half_pulse_count", half_pulses - half_base, 0);
    checkOutput("half_total", half_pulses, 0);
`endif

    // Reset mid-queue with count 7 and the FSM in WAIT_RDY.
    writeBytes(8'hD0, 8);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("midq_load", bus.load, 1);
    checkOutput("midq_tx_data", bus.tx_data, 8'hD0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("midq_count", bus.count, 7);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_load", bus.load, 0);
    checkOutput("async_rst_count", bus.count, 0);
    checkOutput("async_rst_empty", bus.empty, 1);
    checkOutput("async_rst_tx_data", bus.tx_data, 8'h00);
    bus.tx_rdy = 1'b1;
    step();
    checkOutput("rst_held_count", bus.count, 0);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("post_rst_count1", bus.count, 1);
    checkOutput("post_rst_load0", bus.load, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_rst_load", bus.load, 1);
    checkOutput("post_rst_tx_data", bus.tx_data, 8'h77);
    checkOutput("post_rst_count0", bus.count, 0);

    // Reset while load is high drops it without waiting for a clock edge.
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_load_drop", bus.load, 0);
    step();
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
